// File: rtl/branch_resolve.sv
// Branch resolution unit: keeps in-flight predictions in a circular FIFO,
// compares each against the execute-stage outcome, and produces predictor
// history updates, mispredict flush/redirect, statistics and a sticky
// protocol-error flag.
module branch_resolve #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    input  logic             pred_taken,
    input  logic [31:0]      pred_pc,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [31:0]      res_pc,
    input  logic [31:0]      res_target,
    output logic             history,
    output logic             hist_valid,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic             q_full,
    output logic             q_empty,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic             seq_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry layout: {pc[31:0], taken}
    logic [32:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    logic             history_q, history_d;
    logic             hist_valid_q, hist_valid_d;
    logic             flush_q, flush_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic             seq_err_q, seq_err_d;

    logic             full, empty;
    logic             deq, enq, mispredict;
    logic [31:0]      head_pc;
    logic             head_taken;

    assign full       = (count_q == (AW+1)'(DEPTH));
    assign empty      = (count_q == '0);
    assign head_pc    = mem_q[rd_ptr_q][32:1];
    assign head_taken = mem_q[rd_ptr_q][0];

    assign deq        = res_valid && !empty;
    assign mispredict = deq && (head_taken != res_taken);
    // A same-cycle dequeue frees a slot, so a full queue can still accept;
    // a mispredict squashes everything including the incoming prediction.
    assign enq        = pred_valid && (!full || deq) && !mispredict;

    // Queue storage write; entries need no reset since occupancy guards reads
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= {pred_pc, pred_taken};
        end
    end

    // Next-state logic for pointers, occupancy, outputs and statistics
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        history_d     = history_q;
        hist_valid_d  = deq;
        flush_d       = mispredict;
        redirect_pc_d = redirect_pc_q;
        br_cnt_d      = br_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        seq_err_d     = seq_err_q;

        if (mispredict) begin
            // Squash all in-flight work: pointers collapse, queue empties
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
            if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
            if (enq && !deq)      count_d = count_q + (AW+1)'(1);
            else if (deq && !enq) count_d = count_q - (AW+1)'(1);
        end

        if (deq) begin
            history_d = res_taken;
            if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_W'(1);
        end

        if (mispredict) begin
            redirect_pc_d = res_taken ? res_target : (res_pc + 32'd4);
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end

        // Protocol errors: overflow drop, underflow resolve, PC mismatch
        if (pred_valid && full && !deq)        seq_err_d = 1'b1;
        if (res_valid && empty)                seq_err_d = 1'b1;
        if (deq && (head_pc != res_pc))        seq_err_d = 1'b1;
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            history_q     <= 1'b0;
            hist_valid_q  <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
            br_cnt_q      <= '0;
            miss_cnt_q    <= '0;
            seq_err_q     <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            history_q     <= history_d;
            hist_valid_q  <= hist_valid_d;
            flush_q       <= flush_d;
            redirect_pc_q <= redirect_pc_d;
            br_cnt_q      <= br_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            seq_err_q     <= seq_err_d;
        end
    end

    assign history     = history_q;
    assign hist_valid  = hist_valid_q;
    assign flush       = flush_q;
    assign redirect_pc = redirect_pc_q;
    assign q_full      = full;
    assign q_empty     = empty;
    assign br_cnt      = br_cnt_q;
    assign miss_cnt    = miss_cnt_q;
    assign seq_err     = seq_err_q;

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter DEPTH, default 4, in-flight branch queue depth (power of 2, 2..16).
REQ-002 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pred_valid  input  1  fetch-stage branch detected (from predictor branch output).
REQ-006 SHALL have port pred_taken  input  1  predicted direction (MSB of predictor 2-bit taken state).
REQ-007 SHALL have port pred_pc  input  32  PC of predicted branch.
REQ-008 SHALL have port res_valid  input  1  execute stage resolves oldest in-flight branch.
REQ-009 SHALL have port res_taken  input  1  actual branch outcome.
REQ-010 SHALL have port res_pc  input  32  PC of resolved branch.
REQ-011 SHALL have port res_target  input  32  computed branch target.
REQ-012 SHALL have port history  output  1  actual outcome fed to predictor FSM.
REQ-013 SHALL have port hist_valid  output  1  one-cycle pulse qualifying history.
REQ-014 SHALL have port flush  output  1  one-cycle mispredict flush pulse.
REQ-015 SHALL have port redirect_pc  output  32  corrected fetch PC, valid while flush=1.
REQ-016 SHALL have port q_full  output  1  queue holds DEPTH entries.
REQ-017 SHALL have port q_empty  output  1  queue holds zero entries.
REQ-018 SHALL have port br_cnt  output  CNT_W  resolved-branch count.
REQ-019 SHALL have port miss_cnt  output  CNT_W  mispredict count.
REQ-020 SHALL have port seq_err  output  1  sticky protocol-error flag.

Function
REQ-021 SHALL store {pred_pc, pred_taken} in a circular FIFO of DEPTH entries; write/read pointers wrap modulo DEPTH.
REQ-022 SHALL enqueue when pred_valid=1 and (q_full=0 or a dequeue occurs that cycle) and no mispredict is detected that cycle.
REQ-023 SHALL drop pred_valid when q_full=1 with no same-cycle dequeue, and set seq_err.
REQ-024 SHALL dequeue the head entry when res_valid=1 and q_empty=0.
REQ-025 SHALL ignore res_valid when q_empty=1 (no counter/output change) and set seq_err.
REQ-026 SHALL set seq_err when a dequeued head PC differs from res_pc; resolution otherwise proceeds normally.
REQ-027 SHALL detect mispredict when a dequeue occurs and head pred_taken != res_taken.
REQ-028 SHALL register outputs: on the cycle after a dequeue, hist_valid=1 and history=res_taken; otherwise hist_valid=0 and history holds its last value.
REQ-029 SHALL, on the cycle after a mispredict, assert flush=1 for exactly one cycle, with redirect_pc = res_target if res_taken=1, else res_pc+4 (modulo 2^32).
REQ-030 SHALL, on a mispredict, empty the whole queue at the same clock edge (pointers equal, count 0), squashing all younger entries; a same-cycle pred_valid is discarded without setting seq_err.
REQ-031 SHALL increment br_cnt on every dequeue and miss_cnt on every mispredict, each saturating at 2^CNT_W-1.
REQ-032 SHALL derive q_full and q_empty from a registered occupancy count (0..DEPTH); simultaneous enqueue and dequeue leaves the count unchanged.
REQ-033 SHALL clear seq_err only by reset.

Reset
REQ-034 SHALL, while rst=1 at a clock edge, clear pointers and count, and drive history=0, hist_valid=0, flush=0, redirect_pc=0, br_cnt=0, miss_cnt=0, seq_err=0, q_empty=1, q_full=0.
REQ-035 SHALL give rst priority over all simultaneous pred_valid/res_valid activity; in-flight entries are discarded; normal operation resumes on the first edge with rst=0.

Verification
REQ-036 SHALL be covered: enqueue pc 0x100 taken=1, resolve res_taken=1 -> hist_valid pulse with history=1, flush=0, br_cnt=1, miss_cnt=0.
REQ-037 SHALL be covered: enqueue 0x200 taken=0 and 0x204, resolve 0x200 res_taken=1 target 0x300 -> next cycle flush=1, redirect_pc=0x300, q_empty=1, miss_cnt=1.
REQ-038 SHALL be covered: enqueue 0x400 taken=1, resolve res_taken=0 -> redirect_pc=0x404, flush exactly one cycle.
REQ-039 SHALL be covered: DEPTH+1 enqueues without dequeue -> q_full=1 after 4, 5th dropped, seq_err=1; then enqueue+dequeue in the same cycle while full -> count stays 4.
REQ-040 SHALL be covered: res_valid with empty queue -> no hist_valid, counters unchanged, seq_err=1; res_pc mismatching the head -> seq_err=1.
REQ-041 SHALL be covered: rst asserted with 3 entries queued and a mispredict pending -> all outputs at reset values next cycle, no flush pulse.
